bird_column: RTL

BIRD_COLUMN -- requirements
Module: bird_column

---
 rtl/flappy_pkg.sv | 19 +
 rtl/bird_column_if.sv | 36 +++
 rtl/bird_column_tick_divider.sv | 34 +++
 rtl/bird_column.sv | 117 +++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared game definitions for the bird column and the pipe generator:
//   state_t  - bird FSM state encoding (IDLE, FLY, DEAD)
//   ROWS     - default LED rows per column
//   TICK_DIV - default clock cycles per game tick
// -----------------------------------------------------------------------------
package flappy_pkg;

    localparam int ROWS     = 8;
    localparam int TICK_DIV = 1792;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DEAD = 2'd2
    } state_t;

endpackage

// File: rtl/bird_column_if.sv
// -----------------------------------------------------------------------------
// bird_column_if
// Signal bundle between the game controller / LED driver and bird_column.
//   key       - flap button level (synchronised), 1 = pressed
//   restart   - single-cycle pulse, leave DEAD / return to IDLE
//   pipe_col  - lit pipe rows in the bird's column, bit 0 = bottom
//   bird_rows - one-hot bird position for the LED driver
//   bird_pos  - bird row index, 0 = bottom
//   dead      - high while in DEAD
//   tick      - one-cycle game-tick strobe
// master drives the inputs and observes the outputs; slave is bird_column.
// -----------------------------------------------------------------------------
interface bird_column_if #(
    parameter int ROWS = flappy_pkg::ROWS
);
    localparam int PW = $clog2(ROWS);

    logic            key;
    logic            restart;
    logic [ROWS-1:0] pipe_col;
    logic [ROWS-1:0] bird_rows;
    logic [PW-1:0]   bird_pos;
    logic            dead;
    logic            tick;

    modport master (
        output key, restart, pipe_col,
        input  bird_rows, bird_pos, dead, tick
    );

    modport slave (
        input  key, restart, pipe_col,
        output bird_rows, bird_pos, dead, tick
    );

endinterface

// File: rtl/bird_column_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running counter 0..TICK_DIV-1; tick is high exactly in the cycle the
// count equals TICK_DIV-1.
//   clock - system clock, rising edge
//   reset - synchronous, active-high; clears the count
//   tick  - game-tick strobe
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = flappy_pkg::TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/bird_column.sv
// -----------------------------------------------------------------------------
// bird_column
// Bird position state machine for one LED column of the flappy-bird game.
//   clock - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - bird_column_if.slave: key, restart, pipe_col in;
//           bird_rows, bird_pos, dead, tick out
// The bird falls one row per tick, climbs FLAP_ROWS (saturating at the top)
// on a tick after a key press, and dies on hitting the ground or a pipe.
// -----------------------------------------------------------------------------
module bird_column #(
    parameter int ROWS      = flappy_pkg::ROWS,
    parameter int TICK_DIV  = flappy_pkg::TICK_DIV,
    parameter int FLAP_ROWS = 1,
    parameter int START_ROW = ROWS / 2
) (
    input  logic          clock,
    input  logic          reset,
    bird_column_if.slave  bus
);

    import flappy_pkg::*;

    localparam int            PW      = $clog2(ROWS);
    localparam logic [PW-1:0] TOP_ROW = PW'(ROWS - 1);
    localparam logic [PW-1:0] START   = PW'(START_ROW);
    localparam logic [PW:0]   FLAP    = (PW + 1)'(FLAP_ROWS);

    state_t        r_state;
    logic [PW-1:0] r_pos;
    logic          r_pending;
    logic          r_key_prev;

    logic          w_tick;
    logic          w_edge;
    logic          w_hit;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_up;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_edge = bus.key & ~r_key_prev;
    assign w_hit  = bus.pipe_col[r_pos];

    // One extra bit so the climb can be compared against the top row
    // without wrapping.
    assign w_sum = {1'b0, r_pos} + FLAP;
    assign w_up  = (w_sum > {1'b0, TOP_ROW}) ? TOP_ROW : w_sum[PW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pos      <= START;
            r_pending  <= 1'b0;
            r_key_prev <= 1'b0;
        end else begin
            r_key_prev <= bus.key;
            case (r_state)
                IDLE: begin
                    r_pos     <= START;
                    r_pending <= 1'b0;
                    // Restart outranks a same-cycle key edge; the edge that
                    // launches the bird is consumed, not queued as a flap.
                    if (!bus.restart && w_edge) begin
                        r_state <= FLY;
                    end
                end
                FLY: begin
                    if (bus.restart) begin
                        r_state   <= IDLE;
                        r_pos     <= START;
                        r_pending <= 1'b0;
                    end else if (w_hit) begin
                        // Collision freezes the bird, ignoring any tick.
                        r_state <= DEAD;
                    end else if (w_tick) begin
                        // An edge in the tick cycle queues for the next tick.
                        r_pending <= w_edge;
                        if (r_pending) begin
                            r_pos <= w_up;
                        end else if (r_pos != '0) begin
                            r_pos <= r_pos - 1'b1;
                        end else begin
                            r_state <= DEAD;
                        end
                    end else if (w_edge) begin
                        r_pending <= 1'b1;
                    end
                end
                DEAD: begin
                    if (bus.restart) begin
                        r_state   <= IDLE;
                        r_pos     <= START;
                        r_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pos     <= START;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bird_rows = ROWS'(1) << r_pos;
    assign bus.bird_pos  = r_pos;
    assign bus.dead      = (r_state == DEAD);
    assign bus.tick      = w_tick;

endmodule
